// File: rtl/stack_sequencer_if.sv
// Command-side handshake between a decoder/CPU front end and stack_sequencer.
// master = front end issuing opcodes, slave = the sequencer.
interface stack_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_lit;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [WIDTH-1:0] tos;
  logic             tos_valid;

  modport master (
    output cmd_valid, cmd_op, cmd_lit,
    input  cmd_ready, done, err, err_code, tos, tos_valid
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_lit,
    output cmd_ready, done, err, err_code, tos, tos_valid
  );
endinterface

// File: rtl/stack_sequencer.sv
// Expands Forth-style opcodes into fixed sequences of LIFO stack-port cycles;
// sole driver of the stack's push/pop/peek/poke ports.
module stack_sequencer #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int DEP_W = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  stack_sequencer_if.slave cmd,
  output logic             st_push_en,
  output logic             st_pop_en,
  output logic             st_peek_en,
  output logic             st_poke_en,
  output logic [WIDTH-1:0] st_data_in,
  output logic [IDX_W-1:0] st_index,
  input  logic [WIDTH-1:0] st_data_out,
  input  logic             st_full,
  input  logic             st_empty,
  input  logic [DEP_W-1:0] st_depth
);

  typedef enum logic [2:0] {
    S_IDLE, S_STEP1, S_STEP2, S_STEP3, S_FIN, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_PUSH, OP_DROP, OP_DUP, OP_SWAP, OP_OVER, OP_ADD, OP_SUB
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_in;
  logic [WIDTH-1:0] lit_q, a_q, b_q;
  logic [1:0]       err_code_q;
  logic             accept, underflow, overflow;

  assign op_in  = op_t'(cmd.cmd_op);
  assign accept = cmd.cmd_valid && (state_q == S_IDLE);

  // Legality is judged on the stack status present at the accept edge.
  assign underflow = ((op_in inside {OP_DROP, OP_DUP}) && (st_depth < DEP_W'(1))) ||
                     ((op_in inside {OP_SWAP, OP_OVER, OP_ADD, OP_SUB}) && (st_depth < DEP_W'(2)));
  assign overflow  = (op_in inside {OP_PUSH, OP_DUP, OP_OVER}) && st_full;

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign cmd.done      = (state_q == S_FIN);
  assign cmd.err       = (state_q == S_ERR);
  assign cmd.err_code  = err_code_q;
  assign cmd.tos_valid = (state_q == S_IDLE) && !st_empty;
  assign cmd.tos       = (state_q == S_IDLE) ? st_data_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      lit_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      err_code_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= op_in;
        lit_q <= cmd.cmd_lit;
        if (underflow)     err_code_q <= 2'd1;
        else if (overflow) err_code_q <= 2'd2;
      end
      if (state_q == S_STEP1 && (op_q inside {OP_SWAP, OP_ADD, OP_SUB}))
        a_q <= st_data_out;
      if (state_q == S_STEP2 && op_q == OP_SWAP)
        b_q <= st_data_out;
    end
  end

  always_comb begin
    state_d    = state_q;
    st_push_en = 1'b0;
    st_pop_en  = 1'b0;
    st_peek_en = 1'b0;
    st_poke_en = 1'b0;
    st_data_in = '0;
    st_index   = '0;
    case (state_q)
      S_IDLE: begin
        // Keep the top word visible for tos; quiet while reset is held.
        st_peek_en = rst_n;
        if (accept) begin
          if (underflow || overflow) state_d = S_ERR;
          else if (op_in == OP_NOP)  state_d = S_FIN;
          else                       state_d = S_STEP1;
        end
      end
      S_STEP1: begin
        state_d = S_FIN;
        case (op_q)
          OP_PUSH: begin
            st_push_en = 1'b1;
            st_data_in = lit_q;
          end
          OP_DROP: st_pop_en = 1'b1;
          OP_DUP: begin
            st_peek_en = 1'b1;
            st_push_en = 1'b1;
            st_data_in = st_data_out;
          end
          OP_OVER: begin
            st_peek_en = 1'b1;
            st_index   = IDX_W'(1);
            st_push_en = 1'b1;
            st_data_in = st_data_out;
          end
          OP_SWAP: begin
            st_peek_en = 1'b1;
            state_d    = S_STEP2;
          end
          OP_ADD, OP_SUB: begin
            st_peek_en = 1'b1;
            st_pop_en  = 1'b1;
            state_d    = S_STEP2;
          end
          default: state_d = S_FIN;
        endcase
      end
      S_STEP2: begin
        state_d = S_FIN;
        if (op_q == OP_SWAP) begin
          st_peek_en = 1'b1;
          st_poke_en = 1'b1;
          st_index   = IDX_W'(1);
          st_data_in = a_q;
          state_d    = S_STEP3;
        end else if (op_q == OP_ADD || op_q == OP_SUB) begin
          // Operand A was popped in step 1; the new top is the other operand.
          st_peek_en = 1'b1;
          st_poke_en = 1'b1;
          st_data_in = (op_q == OP_ADD) ? (st_data_out + a_q) : (st_data_out - a_q);
        end
      end
      S_STEP3: begin
        st_poke_en = 1'b1;
        st_data_in = b_q;
        state_d    = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer driving a behavioural DEPTH=4 LIFO, with a
// reference stack and a scoreboard of expected outcomes per command.
module tb_stack_sequencer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
  localparam int DEP_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stack_sequencer_if #(.WIDTH(WIDTH)) cmd_if ();

  logic             st_push_en, st_pop_en, st_peek_en, st_poke_en;
  logic [WIDTH-1:0] st_data_in, st_data_out;
  logic [IDX_W-1:0] st_index;
  logic             st_full, st_empty;
  logic [DEP_W-1:0] st_depth;

  stack_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if),
    .st_push_en (st_push_en),
    .st_pop_en  (st_pop_en),
    .st_peek_en (st_peek_en),
    .st_poke_en (st_poke_en),
    .st_data_in (st_data_in),
    .st_index   (st_index),
    .st_data_out(st_data_out),
    .st_full    (st_full),
    .st_empty   (st_empty),
    .st_depth   (st_depth)
  );

  // Behavioural stack: mem[sdepth-1] is the top, index counts down from it.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEP_W-1:0] sdepth;

  assign st_depth = sdepth;
  assign st_full  = (sdepth == DEP_W'(DEPTH));
  assign st_empty = (sdepth == '0);

  always_comb begin
    st_data_out = '0;
    if (st_peek_en && int'(st_index) < int'(sdepth))
      st_data_out = mem[int'(sdepth) - 1 - int'(st_index)];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdepth <= '0;
    end else begin
      if (st_push_en && int'(sdepth) < DEPTH) begin
        mem[int'(sdepth)] <= st_data_in;
        sdepth <= sdepth + 1'b1;
      end else if (st_pop_en && sdepth != '0) begin
        sdepth <= sdepth - 1'b1;
      end
      if (st_poke_en && int'(st_index) < int'(sdepth))
        mem[int'(sdepth) - 1 - int'(st_index)] <= st_data_in;
    end
  end

  int en_cnt = 0;
  int both_cnt = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (st_push_en || st_pop_en || st_poke_en) en_cnt <= en_cnt + 1;
      if (st_push_en && st_pop_en) both_cnt <= both_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    bit is_err;
    int code;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   ref_q[$];
  int   last_code = 0;

  task automatic do_cmd(input logic [2:0] op, input logic [7:0] lit);
    exp_t e;
    int   n, t, a, lat, en0;
    bit   uf, of, seen;
    n  = ref_q.size();
    uf = 1'b0;
    of = 1'b0;
    e.is_err = 1'b0;
    e.lat    = 2;
    case (op)
      3'd0: e.lat = 1;
      3'd1: if (n >= DEPTH) of = 1'b1; else ref_q.push_front(int'(lit));
      3'd2: if (n < 1) uf = 1'b1; else void'(ref_q.pop_front());
      3'd3: if (n < 1) uf = 1'b1; else if (n >= DEPTH) of = 1'b1; else ref_q.push_front(ref_q[0]);
      3'd4: if (n < 2) uf = 1'b1;
            else begin
              t = ref_q[0]; ref_q[0] = ref_q[1]; ref_q[1] = t; e.lat = 4;
            end
      3'd5: if (n < 2) uf = 1'b1; else if (n >= DEPTH) of = 1'b1; else ref_q.push_front(ref_q[1]);
      default: if (n < 2) uf = 1'b1;
            else begin
              a = ref_q.pop_front();
              ref_q[0] = (op == 3'd6) ? ((ref_q[0] + a) & 255) : ((ref_q[0] - a) & 255);
              e.lat = 3;
            end
    endcase
    if (uf || of) begin
      e.is_err  = 1'b1;
      e.lat     = 1;
      last_code = uf ? 1 : 2;
    end
    e.code = last_code;
    sb.push_back(e);

    en0 = en_cnt;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_lit   = lit;
    cmd_if.cmd_valid = 1'b1;
    check("ready_idle", cmd_if.cmd_ready, 1);
    @(posedge clk); #1;
    lat  = 1;
    seen = 1'b0;
    // cmd_valid stays high through the busy cycles; it must not be re-accepted.
    while (!seen && lat <= 8) begin
      if (cmd_if.done || cmd_if.err) seen = 1'b1;
      else begin
        check("ready_busy", cmd_if.cmd_ready, 0);
        @(posedge clk); #1;
        lat++;
      end
    end
    cmd_if.cmd_valid = 1'b0;
    e = sb.pop_front();
    check("completion_seen", seen, 1);
    if (seen) begin
      check("err_pulse", cmd_if.err, e.is_err);
      check("done_pulse", cmd_if.done, !e.is_err);
      check("latency", lat, e.lat);
      check("ready_fin", cmd_if.cmd_ready, 0);
      if (e.is_err) check("err_no_enables", en_cnt - en0, 0);
    end
    @(posedge clk); #1;
    check("pulse_clear", cmd_if.done | cmd_if.err, 0);
    check("err_code", cmd_if.err_code, e.code);
    check("depth", st_depth, ref_q.size());
    check("tos_valid", cmd_if.tos_valid, ref_q.size() != 0);
    if (ref_q.size() > 0) check("tos", cmd_if.tos, ref_q[0]);
    if (ref_q.size() > 1 && sdepth >= 2) check("idx1", mem[int'(sdepth) - 2], ref_q[1]);
  endtask

  initial begin
    rst_n            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_lit   = '0;
    #12;
    check("rst_ready", cmd_if.cmd_ready, 1);
    check("rst_done", cmd_if.done, 0);
    check("rst_err", cmd_if.err, 0);
    check("rst_err_code", cmd_if.err_code, 0);
    check("rst_tos_valid", cmd_if.tos_valid, 0);
    check("rst_enables", {st_push_en, st_pop_en, st_peek_en, st_poke_en}, 0);
    check("rst_index", st_index, 0);
    check("rst_data_in", st_data_in, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmd(3'd2, 8'd0);                        // DROP on empty -> underflow
    do_cmd(3'd1, 8'd5); do_cmd(3'd1, 8'd9); do_cmd(3'd6, 8'd0);   // 14
    do_cmd(3'd2, 8'd0);
    do_cmd(3'd1, 8'd3); do_cmd(3'd1, 8'd7); do_cmd(3'd7, 8'd0);   // 252
    do_cmd(3'd2, 8'd0);
    do_cmd(3'd1, 8'd250); do_cmd(3'd1, 8'd10); do_cmd(3'd6, 8'd0); // 4
    do_cmd(3'd2, 8'd0);
    do_cmd(3'd1, 8'd1); do_cmd(3'd1, 8'd2); do_cmd(3'd4, 8'd0);   // SWAP
    do_cmd(3'd5, 8'd0); do_cmd(3'd3, 8'd0);    // OVER, DUP -> full
    do_cmd(3'd3, 8'd0);                        // DUP when full -> overflow
    do_cmd(3'd0, 8'd0);                        // NOP keeps err_code
    do_cmd(3'd1, 8'd99);                       // PUSH when full -> overflow
    do_cmd(3'd5, 8'd0);                        // OVER when full -> overflow
    repeat (4) do_cmd(3'd2, 8'd0);
    do_cmd(3'd1, 8'd1); do_cmd(3'd4, 8'd0);    // SWAP with one entry
    do_cmd(3'd2, 8'd0);

    for (int i = 0; i < 60; i++)
      do_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));

    // Reset while a SWAP is in its second step.
    while (ref_q.size() > 0) do_cmd(3'd2, 8'd0);
    do_cmd(3'd1, 8'd1); do_cmd(3'd1, 8'd2);
    cmd_if.cmd_op    = 3'd4;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("swap_in_s2", st_poke_en, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", cmd_if.cmd_ready, 1);
    check("midrst_done", cmd_if.done, 0);
    check("midrst_err", cmd_if.err, 0);
    check("midrst_writes", {st_push_en, st_pop_en, st_poke_en}, 0);
    cmd_if.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst_hold_done", cmd_if.done | cmd_if.err, 0);
    check("midrst_err_code", cmd_if.err_code, 0);
    ref_q.delete();
    last_code = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    do_cmd(3'd1, 8'd7);
    do_cmd(3'd3, 8'd0);
    do_cmd(3'd6, 8'd0);                        // 14

    check("push_pop_exclusive", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=%0d expected=%0d", checks, 0);
    $fatal(1, "timeout");
  end
endmodule
